// File: rtl/pci_bus_arbiter_if.sv
// rtl/pci_bus_arbiter_if.sv - PCI arbitration signal bundle shared by the arbiter and bus agents
//
// Signals (all active low, PCI naming):
//   FRAME  bus FRAME#, driven by the current initiator
//   IRDY   bus IRDY#, driven by the current initiator
//   REQ    REQ#[3:0], one per bus-master agent
//   GNT    GNT#[3:0], one per agent, driven by the arbiter
// Modports:
//   master  arbiter view: samples FRAME/IRDY/REQ, drives GNT
//   slave   agent/bus view: drives FRAME/IRDY/REQ, observes GNT
interface pci_bus_arbiter_if;
    logic       FRAME;
    logic       IRDY;
    logic [3:0] REQ;
    logic [3:0] GNT;

    modport master (
        input  FRAME,
        input  IRDY,
        input  REQ,
        output GNT
    );

    modport slave (
        output FRAME,
        output IRDY,
        output REQ,
        input  GNT
    );
endinterface

// File: rtl/pci_bus_arbiter.sv
// rtl/pci_bus_arbiter.sv - four-agent round-robin PCI bus arbiter with parking and hidden arbitration
//
// Ports:
//   CLK    PCI clock, all state updates on the rising edge
//   RESET  asynchronous active-low reset (PCI RST#)
//   bus    pci_bus_arbiter_if.master: samples FRAME#/IRDY#/REQ#[3:0], drives registered GNT#[3:0]
// Parameters:
//   PARK_AGENT     agent parked on when nothing is requesting after reset
//   GRANT_TIMEOUT  idle-bus clocks a granted agent may sit on GNT# while another agent waits
module pci_bus_arbiter #(
    parameter int unsigned PARK_AGENT    = 0,
    parameter int unsigned GRANT_TIMEOUT = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    pci_bus_arbiter_if.master bus
);

    localparam logic [1:0] ST_GAP     = 2'd0;
    localparam logic [1:0] ST_GRANTED = 2'd1;
    localparam logic [1:0] ST_BUSY    = 2'd2;

    localparam int unsigned    TW   = $clog2(GRANT_TIMEOUT) + 1;
    localparam logic [TW-1:0]  TMAX = TW'(GRANT_TIMEOUT - 1);

    logic [1:0]    state_q, state_d;
    logic [1:0]    owner_q, owner_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    gnt_q,   gnt_d;

    logic [1:0] winner;
    logic [1:0] idx;
    logic       found;
    logic       bus_idle;
    logic       other_req;

    assign bus_idle  = bus.FRAME & bus.IRDY;
    // Any agent other than the current owner driving REQ# low.
    assign other_req = |(~bus.REQ & ~(4'b0001 << owner_q));

    // Round-robin search starting just after the owner; the owner itself is
    // examined last, so with no requests at all the grant stays where it is.
    // Owner is reset to PARK_AGENT, so the first GAP parks there.
    always_comb begin
        winner = owner_q;
        found  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= 4; k++) begin
            idx = owner_q + 2'(k);
            if (!found && !bus.REQ[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        timer_d = timer_q;
        gnt_d   = gnt_q;
        case (state_q)
            ST_GAP: begin
                owner_d = winner;
                timer_d = '0;
                gnt_d   = ~(4'b0001 << winner);
                state_d = ST_GRANTED;
            end
            ST_GRANTED: begin
                // FRAME# takes precedence over a revoke in the same clock.
                if (!bus.FRAME) begin
                    state_d = ST_BUSY;
                end else if (other_req && (bus.REQ[owner_q] || timer_q == TMAX)) begin
                    gnt_d   = 4'b1111;
                    state_d = ST_GAP;
                end else if (bus_idle && timer_q != TMAX) begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_BUSY: begin
                // Hidden arbitration: pull GNT# while the transfer is still running.
                if (other_req) begin
                    gnt_d   = 4'b1111;
                    state_d = ST_GAP;
                end else if (bus_idle) begin
                    timer_d = '0;
                    state_d = ST_GRANTED;
                end
            end
            default: begin
                gnt_d   = 4'b1111;
                state_d = ST_GAP;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_GAP;
            owner_q <= 2'(PARK_AGENT);
            timer_q <= '0;
            gnt_q   <= 4'b1111;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            timer_q <= timer_d;
            gnt_q   <= gnt_d;
        end
    end

    assign bus.GNT = gnt_q;

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// tb/tb_pci_bus_arbiter.sv - directed self-checking bench for pci_bus_arbiter
module tb_pci_bus_arbiter;

    logic CLK = 1'b0;
    logic RESET;
    int   n_cmp = 0;
    int   n_bad = 0;

    pci_bus_arbiter_if bus ();

    pci_bus_arbiter #(
        .PARK_AGENT    (0),
        .GRANT_TIMEOUT (16)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // One rising edge has passed when this returns; inputs change and outputs
    // are sampled here, half a period away from the active edge.
    task automatic cyc();
        @(negedge CLK);
    endtask

    int         order [8] = '{3, 0, 1, 2, 3, 0, 1, 2};
    int         cur;
    logic [3:0] exp_gnt;

    initial begin
        RESET     = 1'b0;
        bus.FRAME = 1'b1;
        bus.IRDY  = 1'b1;
        bus.REQ   = 4'b1111;
        cyc();
        cyc();
        check("reset_gnt", bus.GNT, 4'b1111);

        // Reset release: one GAP clock, then park on agent 0.
        RESET = 1'b1;
        check("gap_after_reset", bus.GNT, 4'b1111);
        cyc();
        check("park0", bus.GNT, 4'b1110);
        for (int i = 0; i < 100; i++) begin
            cyc();
            check("park0_hold", bus.GNT, 4'b1110);
        end

        // A REQ# pulse that never spans a rising edge is ignored.
        #1 bus.REQ = 4'b1011;
        #2 bus.REQ = 4'b1111;
        cyc();
        check("glitch_ignored", bus.GNT, 4'b1110);

        // Agent 1 requests while agent 0 is parked and idle.
        bus.REQ = 4'b1101;
        cyc();
        check("revoke_gap", bus.GNT, 4'b1111);
        cyc();
        check("grant1", bus.GNT, 4'b1101);

        // Move the grant back to agent 0.
        bus.REQ = 4'b1110;
        cyc();
        check("back_gap", bus.GNT, 4'b1111);
        cyc();
        check("regrant0", bus.GNT, 4'b1110);

        // Agent 0 runs a 5-clock transaction; agent 1 is granted while FRAME# is low.
        bus.REQ   = 4'b1101;
        bus.FRAME = 1'b0;
        cyc();
        check("busy_hold0", bus.GNT, 4'b1110);
        cyc();
        check("hidden_gap", bus.GNT, 4'b1111);
        cyc();
        check("hidden_grant1", bus.GNT, 4'b1101);
        cyc();
        check("frame_low_4", bus.GNT, 4'b1101);
        cyc();
        check("frame_low_5", bus.GNT, 4'b1101);
        bus.FRAME = 1'b1;
        cyc();
        check("idle_keep1", bus.GNT, 4'b1101);

        // Agent 0 granted, requesting, never starts; agent 2 waits for the timeout.
        bus.REQ = 4'b1110;
        cyc();
        check("to0_gap", bus.GNT, 4'b1111);
        cyc();
        check("to0_grant", bus.GNT, 4'b1110);
        bus.REQ = 4'b1010;
        for (int i = 1; i <= 15; i++) begin
            cyc();
            check("timeout_hold", bus.GNT, 4'b1110);
        end
        cyc();
        check("timeout_gap", bus.GNT, 4'b1111);
        cyc();
        check("timeout_grant2", bus.GNT, 4'b1011);

        // All agents requesting, each tenure a one-clock FRAME# pulse.
        bus.REQ = 4'b0000;
        cur     = 2;
        for (int t = 0; t < 8; t++) begin
            bus.FRAME = 1'b0;
            cyc();
            exp_gnt = 4'b1111 ^ (4'b0001 << cur);
            check("rr_busy", bus.GNT, exp_gnt);
            bus.FRAME = 1'b1;
            cyc();
            check("rr_gap", bus.GNT, 4'b1111);
            cyc();
            exp_gnt = 4'b1111 ^ (4'b0001 << order[t]);
            check("rr_grant", bus.GNT, exp_gnt);
            cur = order[t];
        end

        // Reset mid-transaction while agent 2 owns the bus.
        bus.FRAME = 1'b0;
        bus.IRDY  = 1'b0;
        cyc();
        check("mid_txn", bus.GNT, 4'b1011);
        #3 RESET = 1'b0;
        #1 check("async_reset", bus.GNT, 4'b1111);
        bus.REQ   = 4'b1111;
        bus.FRAME = 1'b1;
        bus.IRDY  = 1'b1;
        cyc();
        check("in_reset", bus.GNT, 4'b1111);
        RESET = 1'b1;
        check("gap_after_release", bus.GNT, 4'b1111);
        cyc();
        check("repark0", bus.GNT, 4'b1110);
        cyc();
        check("repark0_hold", bus.GNT, 4'b1110);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pci_bus_arbiter.md
Name: pci_bus_arbiter

Overview:
- Central arbiter for a 33/66 MHz conventional PCI bus with four bus-master agents.
- Samples active-low REQ# lines and FRAME#/IRDY# bus state; drives one registered active-low GNT# per agent.
- Priority is round-robin with bus parking and hidden arbitration.
- Sits beside the host master model and target devices on the shared bus.

Parameters:
- PARK_AGENT, 0: agent parked on when no requests are pending after reset.
- GRANT_TIMEOUT, 16: idle-bus clocks a granted agent may hold GNT# without starting FRAME# while another agent requests.

Ports:
- CLK  input  1  PCI clock; all state updates on rising edge.
- RESET  input  1  asynchronous, active-low reset (PCI RST#).
- FRAME  input  1  PCI FRAME#, active low.
- IRDY  input  1  PCI IRDY#, active low.
- REQ  input  4  REQ#[3:0], active low, one per agent; undriven lines are pulled high (not requesting).
- GNT  output  4  GNT#[3:0], active low, registered; at most one bit low at any time.

Behaviour:
- Bus idle is FRAME=1 and IRDY=1, sampled at the rising edge.
- Reset (RESET=0, asynchronous):
  - GNT=4'b1111, state=GAP, owner=PARK_AGENT, timer=0.
  - Reset asserted mid-transaction drops all grants immediately.
- States:
  - GAP: all GNT high for exactly one clock. Winner is the first requesting agent in round-robin order starting at (owner+1) mod 4. If nothing is requesting, winner=owner, except the first GAP after reset, where winner=PARK_AGENT. Next clock: GNT[winner]=0, owner=winner, timer=0, state=GRANTED.
  - GRANTED: owner holds GNT.
    - FRAME sampled 0 -> BUSY, GNT unchanged.
    - Otherwise, if another agent requests (REQ[i]=0, i != owner) and either REQ[owner]=1 or timer = GRANT_TIMEOUT-1 -> GNT=4'b1111, state=GAP.
    - Otherwise stay in GRANTED; parking persists indefinitely.
    - timer increments only on idle-bus clocks while in GRANTED and saturates.
  - BUSY: a transaction is in progress.
    - Another agent requests -> GNT=4'b1111 the next clock, state=GAP (hidden arbitration). The next winner may be granted while the current transaction finishes; masters are responsible for waiting for idle.
    - No other request and bus idle -> state=GRANTED, timer=0, owner keeps GNT.
    - Otherwise stay in BUSY.
- Grant changes:
  - Every change of owner passes through one all-high GAP clock; GNT never switches directly between two agents.
  - Re-granting the same owner after a GAP is allowed.
- Round robin: the last owner gets lowest priority in the next GAP. Four agents requesting continuously are served 0,1,2,3,0,...
- Simultaneous events:
  - FRAME falling in the same clock that a revoke condition becomes true in GRANTED: FRAME wins (-> BUSY).
  - Requests arriving during GAP are evaluated in that same GAP clock.
- Request pulses shorter than one clock that are not sampled are ignored.
- GNT has no combinational path from inputs.

Test Plan:
- Reset release with REQ=4'b1111 -> GNT=1111 one clock, then GNT=4'b1110 (parked on agent 0) and held for 100 clocks.
- Parked on agent 0, REQ=4'b1101 (agent 1 requests, agent 0 idle) -> next clock GNT=1111, following clock GNT=4'b1101.
- Agent 0 granted; FRAME low for 5 clocks with REQ[1] low -> GNT=1111 one clock after BUSY, then GNT=4'b1101 while FRAME is still low. Agent 1 starts only after FRAME=IRDY=1.
- Agent 0 granted and requesting but never asserting FRAME; agent 2 requesting -> after 16 idle clocks GNT=1111, then GNT=4'b1011.
- REQ=4'b0000 held, each granted agent pulses FRAME low for 1 clock per tenure -> grant order 0,1,2,3,0 with a one-clock all-high gap between each.
- RESET driven low while GNT=4'b1011 mid-transaction -> GNT=1111 asynchronously, without waiting for a clock edge. After release -> GAP, then park on agent 0.
